// File: rtl/pkt_sw_pkg.sv
// Shared types and constants for the switch packet injector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: lane count, destination width, default packet width, injector FSM states, and
// dest_of(), which extracts the destination port from a packet.
package pkt_sw_pkg;

   localparam int NUM_PORTS  = 4;
   localparam int DEST_W     = 2;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } inj_state_t;

   // The destination port travels in the low bits of every packet.
   function automatic logic [DEST_W-1:0] dest_of(input logic [DATA_W_DEF-1:0] pkt);
      return pkt[DEST_W-1:0];
   endfunction

endpackage

// File: rtl/pkt_lane_fifo.sv
// Per-lane packet queue: DEPTH x DATA_W, head presented combinationally from storage.
// Latency: a push is visible at o_head the cycle after it is written (o_empty is registered).
// Backpressure: a push while o_full is high is dropped with no side effect, even if a pop happens too.
// Ports: i_clock, i_reset (async, active-high), i_push/i_data write side, i_pop read side,
//        o_full/o_empty registered status, o_head oldest entry.
module pkt_lane_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
)(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic              o_full,
   output logic              o_empty,
   output logic [DATA_W-1:0] o_head
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_cnt;
   logic              r_full;
   logic              r_empty;

   logic              w_push_ok;
   logic              w_pop_ok;
   logic [PTR_W:0]    w_cnt_nxt;

   assign w_push_ok = i_push & ~r_full;
   assign w_pop_ok  = i_pop & ~r_empty;
   assign w_cnt_nxt = r_cnt + {{PTR_W{1'b0}}, w_push_ok} - {{PTR_W{1'b0}}, w_pop_ok};

   // Storage carries no reset: occupancy is tracked by the pointers alone.
   always_ff @(posedge i_clock) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_cnt   <= w_cnt_nxt;
         r_full  <= (w_cnt_nxt == (PTR_W+1)'(DEPTH));
         r_empty <= (w_cnt_nxt == '0);
      end
   end

   assign o_full  = r_full;
   assign o_empty = r_empty;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/packet_injector.sv
// Four-lane packet source for the switch ingress: per-lane queues, one packet per lane per slot.
// Latency: a push into an empty lane during RUN appears the cycle after the next slot strobe.
// Backpressure: a refused packet (grant low at the strobe) is held and re-presented with o_retry set.
// Ports: i_clock, i_reset (async, active-high), i_enable, i_wr_en/i_wr_data/o_wr_full (lane queues),
//        i_grant (switch accept, sampled on o_fourth), o_start, o_fourth, o_packet_out, o_valid_out,
//        o_retry, o_drop.
// Build option: define PKT_INJ_RETRY_LIMIT_EN to discard a packet after MAX_RETRY retransmissions
//        (o_drop pulses); otherwise retransmission is unlimited and o_drop is tied low.
module packet_injector
   import pkt_sw_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DEPTH       = 4,
   parameter int SLOT_CYCLES = 4,
   parameter int MAX_RETRY   = 3
)(
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_enable,
   input  logic [NUM_PORTS-1:0]        i_wr_en,
   input  logic [NUM_PORTS*DATA_W-1:0] i_wr_data,
   output logic [NUM_PORTS-1:0]        o_wr_full,
   input  logic [NUM_PORTS-1:0]        i_grant,
   output logic                        o_start,
   output logic                        o_fourth,
   output logic [NUM_PORTS*DATA_W-1:0] o_packet_out,
   output logic [NUM_PORTS-1:0]        o_valid_out,
   output logic [NUM_PORTS-1:0]        o_retry,
   output logic [NUM_PORTS-1:0]        o_drop
);
   localparam int               CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(SLOT_CYCLES - 1);

   inj_state_t                  r_state;
   logic [CNT_W-1:0]            r_count;
   logic                        r_start;
   logic [NUM_PORTS*DATA_W-1:0] r_pkt;
   logic [NUM_PORTS-1:0]        r_valid;
   logic [NUM_PORTS-1:0]        r_retry;

   logic                        w_fourth;
   logic                        w_go_idle;
   logic [NUM_PORTS-1:0]        w_empty;
   logic [NUM_PORTS-1:0]        w_full;
   logic [NUM_PORTS-1:0]        w_pop;
   logic [NUM_PORTS-1:0]        w_refused;
   logic [NUM_PORTS-1:0]        w_drop;
   logic [NUM_PORTS-1:0]        w_hold;
   logic [DATA_W-1:0]           w_head [NUM_PORTS];

   // Slot boundary: last cycle of a running, enabled slot.
   assign w_fourth = (r_state == RUN) & i_enable & (r_count == LAST);

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
      pkt_lane_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .i_clock (i_clock),
         .i_reset (i_reset),
         .i_push  (i_wr_en[g]),
         .i_data  (i_wr_data[g*DATA_W +: DATA_W]),
         .i_pop   (w_pop[g]),
         .o_full  (w_full[g]),
         .o_empty (w_empty[g]),
         .o_head  (w_head[g])
      );
   end

`ifdef PKT_INJ_RETRY_LIMIT_EN
   localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);
   logic [NUM_PORTS-1:0][1:0] r_rcnt;
   logic [NUM_PORTS-1:0]      r_drop;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (MAX_RETRY != 0);
`endif

   // Lane decision at a boundary: hold a refused packet unless it has used up its retries,
   // otherwise pop the queue head if there is one.
   always_comb begin
      w_refused = r_valid & ~i_grant;
      w_drop    = '0;
`ifdef PKT_INJ_RETRY_LIMIT_EN
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_drop[i] = w_refused[i] & (r_rcnt[i] == RETRY_LIM);
      end
`endif
      w_hold    = w_refused & ~w_drop;
      w_pop     = {NUM_PORTS{w_fourth}} & ~w_hold & ~w_empty;
      w_go_idle = w_fourth & (&w_empty) & ~(|w_hold) & ~(|i_wr_en);
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_start <= 1'b0;
      end else begin
         r_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_enable && !(&w_empty)) begin
                  r_state <= START;
                  r_start <= 1'b1;
               end
            end
            START: begin
               r_count <= '0;
               r_state <= RUN;
            end
            RUN: begin
               if (i_enable) begin
                  r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
                  if (w_go_idle) r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_pkt   <= '0;
         r_valid <= '0;
         r_retry <= '0;
      end else if (w_fourth) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_hold[i]) begin
               r_retry[i] <= 1'b1;
            end else if (!w_empty[i]) begin
               r_pkt[i*DATA_W +: DATA_W] <= w_head[i];
               r_valid[i]                <= 1'b1;
               r_retry[i]                <= 1'b0;
            end else begin
               r_pkt[i*DATA_W +: DATA_W] <= '0;
               r_valid[i]                <= 1'b0;
               r_retry[i]                <= 1'b0;
            end
         end
      end
   end

`ifdef PKT_INJ_RETRY_LIMIT_EN
   // Retransmission count per lane; cleared whenever the lane moves on to a new packet or goes empty.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_rcnt <= '0;
         r_drop <= '0;
      end else begin
         r_drop <= {NUM_PORTS{w_fourth}} & w_drop;
         if (w_fourth) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               r_rcnt[i] <= w_hold[i] ? r_rcnt[i] + 2'd1 : 2'd0;
            end
         end
      end
   end
   assign o_drop = r_drop;
`else
   assign o_drop = '0;
`endif

   assign o_wr_full    = w_full;
   assign o_start      = r_start;
   assign o_fourth     = w_fourth;
   assign o_packet_out = r_pkt;
   assign o_valid_out  = r_valid;
   assign o_retry      = r_retry;

endmodule

// File: tb/tb_packet_injector.sv
module tb_packet_injector;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int SC    = 4;
   localparam int MAXR  = 3;
`ifdef PKT_INJ_RETRY_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   typedef struct packed {
      logic [4*DW-1:0] pkt;
      logic [3:0]      valid;
      logic [3:0]      retry;
      logic [3:0]      drop;
   } rec_t;

   logic            clk;
   logic            rst;
   logic            enable;
   logic [3:0]      wr_en;
   logic [4*DW-1:0] wr_data;
   logic [3:0]      wr_full;
   logic [3:0]      grant;
   logic            start;
   logic            fourth;
   logic [4*DW-1:0] packet_out;
   logic [3:0]      valid_out;
   logic [3:0]      retry;
   logic [3:0]      drop;

   packet_injector #(
      .DATA_W      (DW),
      .DEPTH       (DEPTH),
      .SLOT_CYCLES (SC),
      .MAX_RETRY   (MAXR)
   ) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_enable     (enable),
      .i_wr_en      (wr_en),
      .i_wr_data    (wr_data),
      .o_wr_full    (wr_full),
      .i_grant      (grant),
      .o_start      (start),
      .o_fourth     (fourth),
      .o_packet_out (packet_out),
      .o_valid_out  (valid_out),
      .o_retry      (retry),
      .o_drop       (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model (spec-level: queues + slot position) ----------------
   logic [DW-1:0] m_q [4][$];
   logic [DW-1:0] m_pkt [4];
   bit            m_valid [4];
   bit            m_retry [4];
   int            m_rc [4];
   int            m_mode;      // 0 idle, 1 start cycle, 2 running
   int            m_pos;       // position within slot
   bit            m_start;
   rec_t          exp_q [$];
   rec_t          cur;
   bit            mon_en = 1'b0;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_q[i].delete();
         m_pkt[i]   = '0;
         m_valid[i] = 1'b0;
         m_retry[i] = 1'b0;
         m_rc[i]    = 0;
      end
      m_mode  = 0;
      m_pos   = 0;
      m_start = 1'b0;
      exp_q.delete();
      cur = '0;
   endtask

   // Apply the effect of the coming rising edge given the inputs currently driven.
   task automatic model_edge(input bit bnd);
      int   pre [4];
      bit   any_ne;
      bit   hold_any;
      rec_t r;
      any_ne   = 1'b0;
      hold_any = 1'b0;
      r        = '0;
      for (int i = 0; i < 4; i++) begin
         pre[i] = m_q[i].size();
         if (pre[i] > 0) any_ne = 1'b1;
      end
      if (bnd) begin
         for (int i = 0; i < 4; i++) begin
            bit refused;
            bit dr;
            refused   = m_valid[i] && !grant[i];
            dr        = LIM && refused && (m_rc[i] == MAXR);
            r.drop[i] = dr;
            if (refused && !dr) begin
               m_retry[i] = 1'b1;
               m_rc[i]++;
               hold_any = 1'b1;
            end else if (pre[i] > 0) begin
               m_pkt[i]   = m_q[i].pop_front();
               m_valid[i] = 1'b1;
               m_retry[i] = 1'b0;
               m_rc[i]    = 0;
            end else begin
               m_pkt[i]   = '0;
               m_valid[i] = 1'b0;
               m_retry[i] = 1'b0;
               m_rc[i]    = 0;
            end
            r.pkt[i*DW +: DW] = m_pkt[i];
            r.valid[i]        = m_valid[i];
            r.retry[i]        = m_retry[i];
         end
         exp_q.push_back(r);
      end
      for (int i = 0; i < 4; i++) begin
         if (wr_en[i] && pre[i] < DEPTH) m_q[i].push_back(wr_data[i*DW +: DW]);
      end
      m_start = 1'b0;
      if (m_mode == 0) begin
         if (enable && any_ne) begin
            m_mode  = 1;
            m_start = 1'b1;
         end
      end else if (m_mode == 1) begin
         m_mode = 2;
         m_pos  = 0;
      end else if (enable) begin
         m_pos = (m_pos + 1) % SC;
         if (bnd && !any_ne && !hold_any && wr_en == 4'b0) m_mode = 0;
      end
   endtask

   // One clock cycle: called at posedge+2, returns at the next posedge+2.
   task automatic cycle(input bit en, input logic [3:0] we, input logic [4*DW-1:0] wd,
                        input logic [3:0] gr);
      bit            bnd;
      logic [3:0]    efull;
      enable  = en;
      wr_en   = we;
      wr_data = wd;
      grant   = gr;
      bnd     = (m_mode == 2) && en && (m_pos == SC - 1);
      for (int i = 0; i < 4; i++) efull[i] = (m_q[i].size() == DEPTH);
      @(negedge clk);
      chk("fourth", {63'd0, fourth}, {63'd0, bnd});
      chk("start", {63'd0, start}, {63'd0, m_start});
      chk("wr_full", {60'd0, wr_full}, {60'd0, efull});
      model_edge(bnd);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      mon_en  = 1'b0;
      rst     = 1'b1;
      enable  = 1'b0;
      wr_en   = '0;
      grant   = '0;
      #1;
      chk("rst_pkt", {32'd0, packet_out}, 64'd0);
      chk("rst_vld_retry_drop", {52'd0, valid_out, retry, drop}, 64'd0);
      chk("rst_start_fourth_full", {58'd0, start, fourth, wr_full}, 64'd0);
      model_reset();
      @(posedge clk);
      #2;
      rst    = 1'b0;
      mon_en = 1'b1;
   endtask

   // ---------------- monitor: pops the scoreboard whenever the DUT strobes a boundary -----------
   initial begin
      bit   f;
      rec_t r;
      forever begin
         @(negedge clk);
         f = fourth;
         if (!mon_en) continue;
         @(posedge clk);
         #1;
         if (!mon_en) continue;
         if (f) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_boundary", 64'd1, 64'd0);
            end else begin
               r   = exp_q.pop_front();
               cur = r;
               chk("bnd_packet_out", {32'd0, packet_out}, {32'd0, r.pkt});
               chk("bnd_valid_retry", {56'd0, valid_out, retry}, {56'd0, r.valid, r.retry});
               chk("bnd_drop", {60'd0, drop}, {60'd0, r.drop});
            end
         end else begin
            chk("hold_packet_out", {32'd0, packet_out}, {32'd0, cur.pkt});
            chk("hold_valid_retry", {56'd0, valid_out, retry}, {56'd0, cur.valid, cur.retry});
            chk("hold_drop", {60'd0, drop}, 64'd0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [3:0] we;
      rst     = 1'b1;
      enable  = 1'b0;
      wr_en   = '0;
      wr_data = '0;
      grant   = '0;
      model_reset();
      @(posedge clk);
      #2;
      do_reset();

      // single packet into lane 0 from idle
      cycle(1'b1, 4'b0001, 32'h0000_00A1, 4'hF);
      for (int c = 0; c < 12; c++) cycle(1'b1, 4'b0, '0, 4'hF);

      // lanes 3 and 2, both headed for port 2; only lane 2 granted
      cycle(1'b1, 4'b1100, 32'h0206_0000, 4'b0100);
      cycle(1'b1, 4'b0100, 32'h0016_0000, 4'b0100);
      for (int c = 0; c < 12; c++) cycle(1'b1, 4'b0, '0, 4'b0100);
      for (int c = 0; c < 8; c++) cycle(1'b1, 4'b0, '0, 4'hF);

      // overfill lane 1 while frozen, then release
      for (int k = 1; k <= 4; k++) cycle(1'b0, 4'b0010, {16'd0, 8'(k), 8'd0}, 4'hF);
      cycle(1'b0, 4'b0010, 32'h0000_FF00, 4'hF);
      for (int c = 0; c < 24; c++) cycle(1'b1, 4'b0, '0, 4'hF);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 4; i++) we[i] = ($urandom_range(0, 9) < 3);
         cycle($urandom_range(0, 9) != 0, we, $urandom(), 4'($urandom()));
      end

      // lane 0 refused forever
      for (int c = 0; c < 8; c++) cycle(1'b1, 4'b0001, $urandom(), 4'b1110);
      for (int c = 0; c < 60; c++) begin
         for (int i = 0; i < 4; i++) we[i] = ($urandom_range(0, 9) < 2);
         cycle(1'b1, we, $urandom(), 4'b1110);
      end

      // mid-slot reset with traffic queued
      for (int c = 0; c < 30; c++) cycle(1'b1, 4'($urandom()), $urandom(), 4'($urandom()));
      do_reset();
      for (int c = 0; c < 200; c++) begin
         for (int i = 0; i < 4; i++) we[i] = ($urandom_range(0, 9) < 3);
         cycle($urandom_range(0, 9) != 0, we, $urandom(), 4'($urandom()));
      end

      // drain everything
      for (int c = 0; c < 60; c++) cycle(1'b1, 4'b0, '0, 4'hF);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
